// File: rtl/sci_acc_pkg.sv
// Shared definitions for the SCE accelerator: operand field widths, requester ids
// and the core arbiter state encoding.
package sci_acc_pkg;

   localparam int NUM_MODE_BITS = 3;
   localparam int NUM_RES_BITS  = 4;
   localparam int IEEE_32BIT    = 32;

   typedef enum logic [0:0] {
      REQ_ROM  = 1'b0,
      REQ_HOST = 1'b1
   } req_id_t;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } arb_state_t;

   function automatic req_id_t other_port(input req_id_t id);
      return (id == REQ_ROM) ? REQ_HOST : REQ_ROM;
   endfunction

endpackage

// File: rtl/sci_acc_tag_fifo.sv
// In-order FIFO of 1-bit requester ids; a push and a pop in the same cycle are both
// honoured, including when the FIFO holds a single entry.
module sci_acc_tag_fifo
   import sci_acc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    reset_n,
   input  logic    push,
   input  logic    pop,
   input  req_id_t wr_id,
   output req_id_t rd_id,
   output logic    empty,
   output logic    full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign rd_id   = req_id_t'(mem_q[rd_ptr_q]);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wr_id;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/sci_acc_core_arbiter.sv
// Round-robin share of the compute core between the ROM DMA stream (port 0) and the
// host port (port 1), with outstanding-op back-pressure and in-order done routing.
module sci_acc_core_arbiter
   import sci_acc_pkg::*;
#(
   parameter int MAX_OUTST = 4,
   parameter int OUTST_W   = $clog2(MAX_OUTST) + 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     req0_vld,
   input  logic [NUM_MODE_BITS-1:0] req0_mode,
   input  logic [NUM_RES_BITS-1:0]  req0_res,
   input  logic [IEEE_32BIT-1:0]    req0_data,
   output logic                     req0_gnt,
   output logic                     req0_done,
   input  logic                     req1_vld,
   input  logic [NUM_MODE_BITS-1:0] req1_mode,
   input  logic [NUM_RES_BITS-1:0]  req1_res,
   input  logic [IEEE_32BIT-1:0]    req1_data,
   output logic                     req1_gnt,
   output logic                     req1_done,
   input  logic                     core_ready,
   input  logic                     core_pop,
   input  logic                     core_op_done,
   input  logic                     result_fifo_ready,
   output logic                     core_req_vld,
   output logic [NUM_MODE_BITS-1:0] core_req_mode,
   output logic [NUM_RES_BITS-1:0]  core_req_res,
   output logic [IEEE_32BIT-1:0]    core_req_data,
   output logic [OUTST_W-1:0]       outst_cnt,
   output logic                     err_spurious_done,
   output arb_state_t               dbg_state
);

   // Handshake: a requester raises reqX_vld with stable fields and holds them until
   // reqX_gnt; the core takes the presented packet in the cycle core_pop is high while
   // core_req_vld is high. Grant and done pulses are combinational, single-cycle.

   arb_state_t               state_q, state_d;
   req_id_t                  winner_q, winner_d;
   req_id_t                  rr_q, rr_d;
   req_id_t                  pick;
   logic [NUM_MODE_BITS-1:0] mode_q, mode_d;
   logic [NUM_RES_BITS-1:0]  res_q, res_d;
   logic [IEEE_32BIT-1:0]    data_q, data_d;
   logic [OUTST_W-1:0]       cnt_q, cnt_d;
   logic                     err_q, err_d;
   logic                     eligible;
   logic                     accept;
   logic                     done_ok;
   req_id_t                  tag_head;
   logic                     tag_empty;
   logic                     tag_full;

   assign eligible = (req0_vld | req1_vld) & core_ready & result_fifo_ready &
                     (cnt_q < OUTST_W'(MAX_OUTST)) & ~tag_full;
   assign accept   = (state_q == PRESENT) & core_pop;
   assign done_ok  = core_op_done & ~tag_empty;

   always_comb begin
      if (req0_vld & req1_vld) begin
         pick = rr_q;
      end else if (req1_vld) begin
         pick = REQ_HOST;
      end else begin
         pick = REQ_ROM;
      end
   end

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      rr_d     = rr_q;
      mode_d   = mode_q;
      res_d    = res_q;
      data_d   = data_q;
      case (state_q)
         IDLE: begin
            if (eligible) begin
               state_d  = PRESENT;
               winner_d = pick;
               mode_d   = (pick == REQ_HOST) ? req1_mode : req0_mode;
               res_d    = (pick == REQ_HOST) ? req1_res  : req0_res;
               data_d   = (pick == REQ_HOST) ? req1_data : req0_data;
            end
         end
         PRESENT: begin
            // The pointer moves on acceptance only, so a stalled winner keeps priority.
            if (core_pop) begin
               state_d = IDLE;
               rr_d    = other_port(winner_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      case ({accept, done_ok})
         2'b10:   cnt_d = cnt_q + OUTST_W'(1);
         2'b01:   cnt_d = cnt_q - OUTST_W'(1);
         default: cnt_d = cnt_q;
      endcase
      err_d = err_q | (core_op_done & tag_empty);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         winner_q <= REQ_ROM;
         rr_q     <= REQ_ROM;
         mode_q   <= '0;
         res_q    <= '0;
         data_q   <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         rr_q     <= rr_d;
         mode_q   <= mode_d;
         res_q    <= res_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   sci_acc_tag_fifo #(
      .DEPTH (MAX_OUTST)
   ) u_tag_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (accept),
      .pop     (core_op_done),
      .wr_id   (winner_q),
      .rd_id   (tag_head),
      .empty   (tag_empty),
      .full    (tag_full)
   );

   assign core_req_vld      = (state_q == PRESENT);
   assign core_req_mode     = mode_q;
   assign core_req_res      = res_q;
   assign core_req_data     = data_q;
   assign req0_gnt          = accept & (winner_q == REQ_ROM);
   assign req1_gnt          = accept & (winner_q == REQ_HOST);
   assign req0_done         = done_ok & (tag_head == REQ_ROM);
   assign req1_done         = done_ok & (tag_head == REQ_HOST);
   assign outst_cnt         = cnt_q;
   assign err_spurious_done = err_q;
   assign dbg_state         = state_q;

endmodule

// File: doc/sci_acc_core_arbiter.md
Name: sci_acc_core_arbiter

Overview:
- Shares the single compute core (`sci_acc_sce_mclrn_comp_core`) between two request sources.
  - Port 0: the ROM DMA stream.
  - Port 1: a host/CSR-issued request port.
- Arbitrates round-robin, presents one registered request at a time to the core and applies outstanding-operation back-pressure.
- Keeps an in-order tag FIFO so that each core `op_done` is routed back to the requester that issued the operation.
- Sits between `rom_dma_top`/host and the core's `in_fifo_*`/`op_pkt_available` inputs.

Parameters:
- MAX_OUTST, 4, max operations accepted by the core but not yet completed (power of 2, 2..16).
- OUTST_W, $clog2(MAX_OUTST)+1, width of the outstanding counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous reset, active-low.
- req0_vld  in  1  ROM DMA request valid; held stable until req0_gnt.
- req0_mode  in  NUM_MODE_BITS  op mode.
- req0_res  in  NUM_RES_BITS  resolution.
- req0_data  in  IEEE_32BIT  operand.
- req0_gnt  out  1  one-cycle pulse: the core accepted the req0 packet.
- req0_done  out  1  one-cycle pulse: a req0 operation completed.
- req1_vld, req1_mode, req1_res, req1_data, req1_gnt, req1_done: same as port 0, for the host port.
- core_ready  in  1  core able to take a packet.
- core_pop  in  1  core consumed the presented packet (`fifo_pop`).
- core_op_done  in  1  core finished one op (`op_done`).
- result_fifo_ready  in  1  RAM write DMA result FIFO has space.
- core_req_vld  out  1  packet valid to the core (`op_pkt_available`).
- core_req_mode  out  NUM_MODE_BITS  registered mode.
- core_req_res  out  NUM_RES_BITS  registered resolution.
- core_req_data  out  IEEE_32BIT  registered operand.
- outst_cnt  out  OUTST_W  current outstanding count.
- err_spurious_done  out  1  sticky: core_op_done arrived with the tag FIFO empty.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, tag FIFO empty, RR pointer = 0 so port 0 wins the first tie. Reset mid-operation discards the held packet and all tags.
- FSM states:
  - IDLE:
    - Eligible when (req0_vld | req1_vld) & core_ready & result_fifo_ready & (outst_cnt < MAX_OUTST).
    - On a cycle N where the arbiter is eligible: select the winner, register its mode/res/data into core_req_*, record the winner id, go to PRESENT.
    - core_req_vld = 1 from cycle N+1.
  - PRESENT:
    - Hold core_req_vld and core_req_* stable.
    - On core_pop: pulse reqX_gnt for the winner that same cycle, push the winner id into the tag FIFO, increment outst_cnt, toggle the RR pointer to the other port, drop core_req_vld next cycle, go to IDLE.
    - Back-to-back: the next arbitration happens in the cycle after the pop; the packet is presented at pop+2. Minimum spacing is therefore 2 cycles per packet.
- Arbitration:
  - Only one request valid: that port wins.
  - Both valid: the port indicated by the RR pointer wins.
  - The RR pointer updates only on accept (core_pop), not on selection.
- Completion:
  - core_op_done pops the tag FIFO head, pulses req<head>_done that same cycle and decrements outst_cnt.
  - core_op_done with the tag FIFO empty: no done pulse, counter unchanged, err_spurious_done set until reset.
- Simultaneous core_pop and core_op_done: push and pop both occur and outst_cnt is unchanged. When the FIFO holds exactly one entry, the head is popped and the new id is written in the same cycle, with no corruption.
- Full condition: outst_cnt == MAX_OUTST blocks arbitration in IDLE. A packet already in PRESENT still completes.
- result_fifo_ready low blocks new arbitration only; it does not revoke a PRESENT packet.
- core_pop outside PRESENT is ignored.
- Counter arithmetic: outst_cnt is OUTST_W bits, saturating logic not needed because the guard prevents overflow. The tag FIFO has depth MAX_OUTST with log2 pointers that wrap naturally.

Decomposition:
- Shared package `sci_acc_pkg`:
  - already holds NUM_MODE_BITS, NUM_RES_BITS, IEEE_32BIT;
  - add `req_id_t` (1-bit enum REQ_ROM=0, REQ_HOST=1);
  - add `arb_state_t` (IDLE, PRESENT).
- Sub-module `sci_acc_tag_fifo`: parameter depth, 1-bit data, push/pop/empty/full, same-cycle push+pop legal.

Test Plan:
- Single port 0 request with mode=2, res=5, data=32'h3F800000, core_ready=1 → core_req_vld rises 1 cycle later with the same fields. Pulse core_pop → req0_gnt pulses that cycle and outst_cnt=1. Pulse core_op_done → req0_done pulses and outst_cnt=0.
- Both ports valid continuously, core pops each packet immediately → grants alternate 0,1,0,1. Four consecutive core_op_done pulses → done order 0,1,0,1.
- Issue 4 accepted ops with no op_done → outst_cnt=4 and core_req_vld stays 0 while req1_vld=1. One core_op_done → arbitration resumes and the next packet is presented 2 cycles later.
- With outst_cnt=1, pulse core_pop and core_op_done in the same cycle → outst_cnt stays 1; tag order is preserved across subsequent completions.
- core_op_done with no outstanding ops → no done pulse, err_spurious_done=1 and sticky. Assert reset_n=0 mid-PRESENT → core_req_vld=0 immediately, outst_cnt=0, err flag cleared.
- Drop result_fifo_ready while req0_vld=1 in IDLE → no present. Drop it while in PRESENT → the packet stays presented and completes on core_pop.
